multi_cycle_controller: RTL and testbench
=========================================

MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 Parameters: none; opcode values SHALL come from the shared opcodes.v defines.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 part_of_inst  in  7  opcode field from instruction register; stable from ID onward.
REQ-005 alu_bcond  in  1  branch-condition result from ALU, valid in EX for BRANCH.
REQ-006 mem_ready  in  1  memory completes the current access this cycle.
REQ-007 ecall_halt  in  1  halt request (x17==10), sampled in ID for ECALL.
REQ-008 ir_write  out  1  load instruction register.
REQ-009 i_or_d  out  1  memory address select: 0=PC, 1=ALUOut.
REQ-010 mem_read, mem_write  out  1 each  memory access request, held level until mem_ready.
REQ-011 mem_to_reg  out  1  writeback source: 1=MDR, 0=ALUOut.
REQ-012 reg_write  out  1  register-file write enable.
REQ-013 pc_to_reg  out  1  writeback PC+4 to rd.
REQ-014 pc_write  out  1  PC update; one pulse per retired instruction.
REQ-015 pc_source  out  2  next PC: 0=PC+4 adder, 1=ALU result, 2=ALUOut.
REQ-016 alu_src_a  out  1  0=PC, 1=rs1 register.
REQ-017 alu_src_b  out  2  0=rs2, 1=immediate, 2=constant 4.
REQ-018 alu_op  out  2  0=add, 1=branch compare, 2=funct-decoded.
REQ-019 is_ecall  out  1  ECALL decoded in ID.
REQ-020 is_halted  out  1  controller is in HALT.
REQ-021 state  out  3  current state: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5.

Function
REQ-022 Outputs not listed for a state/condition SHALL be 0.
REQ-023 Outputs SHALL be combinational from state plus part_of_inst, alu_bcond, mem_ready, ecall_halt.
REQ-024 IF: mem_read=1, i_or_d=0, ir_write=mem_ready; stay in IF until mem_ready=1, then go to ID.
REQ-025 ID: alu_src_a=0, alu_src_b=1, alu_op=0 (PC+imm into ALUOut).
REQ-026 ID with ECALL: is_ecall=1; ecall_halt=1 -> HALT with no pc_write; otherwise pc_write=1, pc_source=0, go to IF.
REQ-027 ID with any other opcode: go to EX.
REQ-028 EX, ARITHMETIC: alu_src_a=1, alu_src_b=0, alu_op=2; go to WB.
REQ-029 EX, ARITHMETIC_IMM: alu_src_a=1, alu_src_b=1, alu_op=2; go to WB.
REQ-030 EX, LOAD/STORE: alu_src_a=1, alu_src_b=1, alu_op=0; go to MEM.
REQ-031 EX, BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write=1, pc_source = alu_bcond ? 2 : 0; go to IF.
REQ-032 EX, JAL: reg_write=1, pc_to_reg=1, pc_write=1, pc_source=2; go to IF.
REQ-033 EX, JALR: alu_src_a=1, alu_src_b=1, alu_op=0, reg_write=1, pc_to_reg=1, pc_write=1, pc_source=1; go to IF.
REQ-034 EX, unrecognised opcode: treat as NOP; pc_write=1, pc_source=0; go to IF.
REQ-035 MEM: i_or_d=1; mem_read=1 for LOAD, mem_write=1 for STORE; stay in MEM until mem_ready.
REQ-036 MEM with mem_ready, LOAD: go to WB.
REQ-037 MEM with mem_ready, STORE: pc_write=1, pc_source=0; go to IF.
REQ-038 WB: reg_write=1, mem_to_reg=(opcode==LOAD), pc_write=1, pc_source=0; go to IF.
REQ-039 HALT: is_halted=1, all other outputs 0; remain in HALT until reset.
REQ-040 Latency (zero wait states): R/I-type 4, load 5, store 4, branch/JAL/JALR 3, ECALL 2 cycles.
REQ-041 A mem_ready seen outside IF or MEM SHALL be ignored.
REQ-042 The controller SHALL never assert mem_read and mem_write in the same cycle.

Reset
REQ-043 While reset=1, all outputs SHALL be 0 and state SHALL load IF on the clock edge; the first post-reset cycle is IF.
REQ-044 Reset in any state, including MEM mid-access and HALT, SHALL abort the access with no reg_write or pc_write.

Verification
REQ-045 Reset, then ADD (0110011), mem_ready always 1 -> state sequence 0,1,2,4,0; reg_write and pc_write high only in WB; pc_source=0.
REQ-046 LOAD (0000011) with mem_ready low 3 MEM cycles -> mem_read=1, i_or_d=1 held 4 cycles; WB asserts mem_to_reg=1 and reg_write=1.
REQ-047 BRANCH (1100011), alu_bcond=1 then alu_bcond=0 -> EX shows pc_source=2, then 0; pc_write=1 both times; no reg_write.
REQ-048 JALR (1100111) -> EX shows reg_write=1, pc_to_reg=1, pc_source=1; state returns to IF after 3 cycles.
REQ-049 ECALL (1110011) with ecall_halt=1 -> is_ecall=1 in ID, then state=5 and is_halted=1 for 10 or more cycles; reset -> state=0.
REQ-050 STORE (0100011) with reset asserted during MEM (mem_ready=0) -> mem_write drops in the reset cycle, no pc_write, next state IF.

Source files
------------

// File: rtl/multi_cycle_controller.sv
// Multi-cycle RISC-V style control unit.
// Sequences each instruction through IF -> ID -> EX -> (MEM) -> (WB) and
// drives the datapath select/enable lines combinationally from the current
// state and the live status inputs. The current state is exported on `state`.
//
// Memory handshake: mem_read / mem_write are level requests that stay high
// while the controller waits in IF or MEM; the access completes in the cycle
// where the request and mem_ready are both high, and the state advances on
// that clock edge. mem_ready in any other state has no effect.
module multi_cycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] part_of_inst,
    input  logic       alu_bcond,
    input  logic       mem_ready,
    input  logic       ecall_halt,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       pc_to_reg,
    output logic       pc_write,
    output logic [1:0] pc_source,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       is_ecall,
    output logic       is_halted,
    output logic [2:0] state
);

    // Opcode values shared with the rest of the core's decode logic.
    localparam logic [6:0] OP_ARITHMETIC     = 7'b0110011;
    localparam logic [6:0] OP_ARITHMETIC_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD           = 7'b0000011;
    localparam logic [6:0] OP_STORE          = 7'b0100011;
    localparam logic [6:0] OP_BRANCH         = 7'b1100011;
    localparam logic [6:0] OP_JAL            = 7'b1101111;
    localparam logic [6:0] OP_JALR           = 7'b1100111;
    localparam logic [6:0] OP_ECALL          = 7'b1110011;

    // pc_source encodings
    localparam logic [1:0] PC_SRC_ADD4   = 2'd0;
    localparam logic [1:0] PC_SRC_ALU    = 2'd1;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd2;

    // alu_src_b encodings
    localparam logic [1:0] SRC_B_RS2 = 2'd0;
    localparam logic [1:0] SRC_B_IMM = 2'd1;

    // alu_op encodings
    localparam logic [1:0] ALU_ADD    = 2'd0;
    localparam logic [1:0] ALU_BRANCH = 2'd1;
    localparam logic [1:0] ALU_FUNCT  = 2'd2;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    state_t cur_state;
    state_t next_state;

    // State register; reset always restarts at instruction fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= ST_IF;
        end else begin
            cur_state <= next_state;
        end
    end

    // Next-state and datapath controls; everything is forced low during reset
    // so an in-flight access or writeback is dropped immediately.
    always_comb begin
        next_state = cur_state;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        pc_to_reg  = 1'b0;
        pc_write   = 1'b0;
        pc_source  = PC_SRC_ADD4;
        alu_src_a  = 1'b0;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALU_ADD;
        is_ecall   = 1'b0;
        is_halted  = 1'b0;
        state      = 3'd0;

        if (reset) begin
            next_state = ST_IF;
        end else begin
            state = cur_state;
            case (cur_state)
                ST_IF: begin
                    mem_read = 1'b1;
                    ir_write = mem_ready;
                    if (mem_ready) begin
                        next_state = ST_ID;
                    end
                end

                ST_ID: begin
                    // PC + immediate lands in ALUOut as a branch/JAL target.
                    alu_src_b = SRC_B_IMM;
                    if (part_of_inst == OP_ECALL) begin
                        is_ecall = 1'b1;
                        if (ecall_halt) begin
                            next_state = ST_HALT;
                        end else begin
                            pc_write   = 1'b1;
                            next_state = ST_IF;
                        end
                    end else begin
                        next_state = ST_EX;
                    end
                end

                ST_EX: begin
                    case (part_of_inst)
                        OP_ARITHMETIC: begin
                            alu_src_a  = 1'b1;
                            alu_op     = ALU_FUNCT;
                            next_state = ST_WB;
                        end
                        OP_ARITHMETIC_IMM: begin
                            alu_src_a  = 1'b1;
                            alu_src_b  = SRC_B_IMM;
                            alu_op     = ALU_FUNCT;
                            next_state = ST_WB;
                        end
                        OP_LOAD, OP_STORE: begin
                            alu_src_a  = 1'b1;
                            alu_src_b  = SRC_B_IMM;
                            next_state = ST_MEM;
                        end
                        OP_BRANCH: begin
                            alu_src_a  = 1'b1;
                            alu_op     = ALU_BRANCH;
                            pc_write   = 1'b1;
                            pc_source  = alu_bcond ? PC_SRC_ALUOUT : PC_SRC_ADD4;
                            next_state = ST_IF;
                        end
                        OP_JAL: begin
                            reg_write  = 1'b1;
                            pc_to_reg  = 1'b1;
                            pc_write   = 1'b1;
                            pc_source  = PC_SRC_ALUOUT;
                            next_state = ST_IF;
                        end
                        OP_JALR: begin
                            alu_src_a  = 1'b1;
                            alu_src_b  = SRC_B_IMM;
                            reg_write  = 1'b1;
                            pc_to_reg  = 1'b1;
                            pc_write   = 1'b1;
                            pc_source  = PC_SRC_ALU;
                            next_state = ST_IF;
                        end
                        default: begin
                            // Unknown opcode retires as a NOP.
                            pc_write   = 1'b1;
                            next_state = ST_IF;
                        end
                    endcase
                end

                ST_MEM: begin
                    i_or_d    = 1'b1;
                    mem_read  = (part_of_inst == OP_LOAD);
                    mem_write = (part_of_inst == OP_STORE);
                    if (mem_ready) begin
                        if (part_of_inst == OP_LOAD) begin
                            next_state = ST_WB;
                        end else begin
                            pc_write   = 1'b1;
                            next_state = ST_IF;
                        end
                    end
                end

                ST_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (part_of_inst == OP_LOAD);
                    pc_write   = 1'b1;
                    next_state = ST_IF;
                end

                ST_HALT: begin
                    is_halted  = 1'b1;
                    next_state = ST_HALT;
                end

                default: begin
                    // Unused encodings recover to fetch.
                    next_state = ST_IF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Self-checking bench for multi_cycle_controller.
// A behavioural model expands each instruction into its expected per-cycle
// control word and the stimulus for that cycle; each test task replays the
// queues against the DUT and compares every cycle.
module tb_multi_cycle_controller;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_ECALL = 7'b1110011;
    localparam logic [6:0] OP_FENCE = 7'b0001111;

    typedef struct packed {
        logic [2:0] st;
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       pc_to_reg;
        logic       pc_write;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       is_ecall;
        logic       is_halted;
    } out_t;

    typedef struct packed {
        logic       rst;
        logic [6:0] op;
        logic       bc;
        logic       eh;
        logic       mr;
    } stim_t;

    localparam int W = $bits(out_t);

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] part_of_inst = '0;
    logic       alu_bcond = 1'b0;
    logic       mem_ready = 1'b0;
    logic       ecall_halt = 1'b0;
    logic       ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_write;
    logic       pc_to_reg, pc_write, alu_src_a, is_ecall, is_halted;
    logic [1:0] pc_source, alu_src_b, alu_op;
    logic [2:0] state;

    always #5 clk = ~clk;

    multi_cycle_controller dut (
        .clk          (clk),
        .reset        (reset),
        .part_of_inst (part_of_inst),
        .alu_bcond    (alu_bcond),
        .mem_ready    (mem_ready),
        .ecall_halt   (ecall_halt),
        .ir_write     (ir_write),
        .i_or_d       (i_or_d),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_to_reg   (mem_to_reg),
        .reg_write    (reg_write),
        .pc_to_reg    (pc_to_reg),
        .pc_write     (pc_write),
        .pc_source    (pc_source),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .is_ecall     (is_ecall),
        .is_halted    (is_halted),
        .state        (state)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    stim_t        stim_q[$];
    int           pass_cnt = 0;
    int           total_cnt = 0;

    // ---------------- driver ----------------
    function automatic out_t sample_dut();
        out_t o;
        o.st = state;             o.ir_write = ir_write;
        o.i_or_d = i_or_d;        o.mem_read = mem_read;
        o.mem_write = mem_write;  o.mem_to_reg = mem_to_reg;
        o.reg_write = reg_write;  o.pc_to_reg = pc_to_reg;
        o.pc_write = pc_write;    o.pc_source = pc_source;
        o.alu_src_a = alu_src_a;  o.alu_src_b = alu_src_b;
        o.alu_op = alu_op;        o.is_ecall = is_ecall;
        o.is_halted = is_halted;
        return o;
    endfunction

    // Drive one cycle's inputs just after the rising edge, sample at the falling edge.
    task automatic step(input stim_t s, output out_t o);
        @(posedge clk);
        #1;
        reset        = s.rst;
        part_of_inst = s.op;
        alu_bcond    = s.bc;
        ecall_halt   = s.eh;
        mem_ready    = s.mr;
        @(negedge clk);
        o = sample_dut();
    endtask

    // ---------------- reference model ----------------
    // Inputs that do not matter in a given cycle are randomised.
    function automatic stim_t rand_stim(input logic [6:0] op);
        stim_t s;
        s.rst = 1'b0;
        s.op  = op;
        s.bc  = 1'($urandom_range(0, 1));
        s.eh  = 1'($urandom_range(0, 1));
        s.mr  = 1'($urandom_range(0, 1));
        return s;
    endfunction

    function automatic void push(input out_t o, input stim_t s);
        exp_q.push_back(o);
        stim_q.push_back(s);
    endfunction

    // Expected behaviour of one instruction from fetch to retirement.
    // if_wait / mem_wait: number of not-ready cycles before the memory answers.
    function automatic void model_instr(input logic [6:0] op, input logic bc,
                                        input logic eh, input int if_wait,
                                        input int mem_wait);
        out_t  o;
        stim_t s;
        bit    is_load, is_store;
        is_load  = (op == OP_LOAD);
        is_store = (op == OP_STORE);

        // Fetch from PC; the IR loads only when memory answers.
        for (int i = 0; i <= if_wait; i++) begin
            o = '0; o.st = 3'd0; o.mem_read = 1'b1; o.ir_write = (i == if_wait);
            s = rand_stim(op); s.mr = (i == if_wait);
            push(o, s);
        end

        // Decode: ALU computes PC + imm.
        o = '0; o.st = 3'd1; o.alu_src_b = 2'd1;
        s = rand_stim(op);
        if (op == OP_ECALL) begin
            o.is_ecall = 1'b1;
            s.eh = eh;
            o.pc_write = !eh;
            push(o, s);
            return;
        end
        push(o, s);

        // Execute.
        o = '0; o.st = 3'd2;
        s = rand_stim(op);
        case (op)
            OP_R:     begin o.alu_src_a = 1; o.alu_op = 2; end
            OP_I:     begin o.alu_src_a = 1; o.alu_src_b = 1; o.alu_op = 2; end
            OP_LOAD, OP_STORE: begin o.alu_src_a = 1; o.alu_src_b = 1; end
            OP_BR: begin
                s.bc = bc;
                o.alu_src_a = 1; o.alu_op = 1; o.pc_write = 1;
                o.pc_source = bc ? 2'd2 : 2'd0;
            end
            OP_JAL:   begin o.reg_write = 1; o.pc_to_reg = 1; o.pc_write = 1; o.pc_source = 2; end
            OP_JALR: begin
                o.alu_src_a = 1; o.alu_src_b = 1;
                o.reg_write = 1; o.pc_to_reg = 1; o.pc_write = 1; o.pc_source = 1;
            end
            default:  o.pc_write = 1;
        endcase
        push(o, s);

        // Data memory access.
        if (is_load || is_store) begin
            for (int i = 0; i <= mem_wait; i++) begin
                o = '0; o.st = 3'd3; o.i_or_d = 1;
                o.mem_read = is_load; o.mem_write = is_store;
                o.pc_write = is_store && (i == mem_wait);
                s = rand_stim(op); s.mr = (i == mem_wait);
                push(o, s);
            end
        end

        // Register writeback.
        if (op == OP_R || op == OP_I || is_load) begin
            o = '0; o.st = 3'd4; o.reg_write = 1; o.pc_write = 1; o.mem_to_reg = is_load;
            push(o, rand_stim(op));
        end
    endfunction

    function automatic void model_reset_cycles(input int n);
        stim_t s;
        for (int i = 0; i < n; i++) begin
            s = rand_stim(7'($urandom_range(0, 127)));
            s.rst = 1'b1;
            push('0, s);
        end
    endfunction

    function automatic void model_halt_cycles(input int n);
        out_t o;
        for (int i = 0; i < n; i++) begin
            o = '0; o.st = 3'd5; o.is_halted = 1'b1;
            push(o, rand_stim(OP_ECALL));
        end
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        out_t o; out_t e; int n = 0;
        model_reset_cycles(3);
        model_instr(OP_I, 1'b0, 1'b0, 0, 0);
        while (exp_q.size() > 0) begin
            step(stim_q.pop_front(), o);
            e = exp_q.pop_front();
            total_cnt++;
            if (o !== e) $display("FAIL reset cyc%0d: got st=%0d ctl=%h, expected st=%0d ctl=%h", n, o.st, o, e.st, e);
            else pass_cnt++;
            n++;
        end
    endtask

    task automatic test_add();
        out_t o; out_t e; int n = 0;
        model_instr(OP_R, 1'b0, 1'b0, 0, 0);
        model_instr(OP_R, 1'b0, 1'b0, 2, 0);
        while (exp_q.size() > 0) begin
            step(stim_q.pop_front(), o);
            e = exp_q.pop_front();
            total_cnt++;
            if (o !== e) $display("FAIL add cyc%0d: got st=%0d ctl=%h, expected st=%0d ctl=%h", n, o.st, o, e.st, e);
            else pass_cnt++;
            n++;
        end
    endtask

    task automatic test_load_wait();
        out_t o; out_t e; int n = 0;
        model_instr(OP_LOAD, 1'b0, 1'b0, 0, 3);
        while (exp_q.size() > 0) begin
            step(stim_q.pop_front(), o);
            e = exp_q.pop_front();
            total_cnt++;
            if (o !== e) $display("FAIL load cyc%0d: got st=%0d ctl=%h, expected st=%0d ctl=%h", n, o.st, o, e.st, e);
            else pass_cnt++;
            n++;
        end
    endtask

    task automatic test_branch();
        out_t o; out_t e; int n = 0;
        model_instr(OP_BR, 1'b1, 1'b0, 0, 0);
        model_instr(OP_BR, 1'b0, 1'b0, 0, 0);
        model_instr(OP_JAL, 1'b0, 1'b0, 0, 0);
        while (exp_q.size() > 0) begin
            step(stim_q.pop_front(), o);
            e = exp_q.pop_front();
            total_cnt++;
            if (o !== e) $display("FAIL branch cyc%0d: got st=%0d ctl=%h, expected st=%0d ctl=%h", n, o.st, o, e.st, e);
            else pass_cnt++;
            n++;
        end
    endtask

    task automatic test_jalr();
        out_t o; out_t e; int n = 0;
        model_instr(OP_JALR, 1'b0, 1'b0, 0, 0);
        model_instr(OP_FENCE, 1'b0, 1'b0, 0, 0);
        while (exp_q.size() > 0) begin
            step(stim_q.pop_front(), o);
            e = exp_q.pop_front();
            total_cnt++;
            if (o !== e) $display("FAIL jalr cyc%0d: got st=%0d ctl=%h, expected st=%0d ctl=%h", n, o.st, o, e.st, e);
            else pass_cnt++;
            n++;
        end
    endtask

    task automatic test_ecall_halt();
        out_t o; out_t e; int n = 0;
        model_instr(OP_ECALL, 1'b0, 1'b0, 1, 0);
        model_instr(OP_ECALL, 1'b0, 1'b1, 0, 0);
        model_halt_cycles(12);
        model_reset_cycles(1);
        model_instr(OP_R, 1'b0, 1'b0, 0, 0);
        while (exp_q.size() > 0) begin
            step(stim_q.pop_front(), o);
            e = exp_q.pop_front();
            total_cnt++;
            if (o !== e) $display("FAIL ecall cyc%0d: got st=%0d ctl=%h, expected st=%0d ctl=%h", n, o.st, o, e.st, e);
            else pass_cnt++;
            n++;
        end
    endtask

    task automatic test_store_reset();
        out_t o; out_t e; int n = 0;
        model_instr(OP_STORE, 1'b0, 1'b0, 0, 3);
        // Keep only the first, not-ready MEM cycle, then reset mid-access.
        for (int i = 0; i < 3; i++) begin
            void'(exp_q.pop_back());
            void'(stim_q.pop_back());
        end
        model_reset_cycles(1);
        model_instr(OP_STORE, 1'b0, 1'b0, 0, 0);
        while (exp_q.size() > 0) begin
            step(stim_q.pop_front(), o);
            e = exp_q.pop_front();
            total_cnt++;
            if (o !== e) $display("FAIL store_rst cyc%0d: got st=%0d ctl=%h, expected st=%0d ctl=%h", n, o.st, o, e.st, e);
            else pass_cnt++;
            n++;
        end
    endtask

    task automatic test_back_to_back();
        out_t o; out_t e; int n = 0;
        logic [6:0] ops [9] = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR, OP_ECALL, OP_FENCE};
        logic [6:0] op;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 9) == 0) op = 7'($urandom_range(0, 127));
            else op = ops[$urandom_range(0, 8)];
            model_instr(op, 1'($urandom_range(0, 1)), 1'b0,
                        $urandom_range(0, 3), $urandom_range(0, 3));
        end
        while (exp_q.size() > 0) begin
            step(stim_q.pop_front(), o);
            e = exp_q.pop_front();
            total_cnt++;
            if (o !== e) $display("FAIL b2b cyc%0d: got st=%0d ctl=%h, expected st=%0d ctl=%h", n, o.st, o, e.st, e);
            else pass_cnt++;
            total_cnt++;
            if (o.mem_read && o.mem_write) $display("FAIL b2b_rw_excl cyc%0d: got rd=%b wr=%b, expected not both", n, o.mem_read, o.mem_write);
            else pass_cnt++;
            n++;
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_add();
        test_load_wait();
        test_branch();
        test_jalr();
        test_ecall_halt();
        test_store_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
